binary_octal_stream_dec: RTL

- Streaming 3-to-8 decoder: the inverse of the team's one-hot octal-to-binary encoder.
- Accepts 3-bit binary codes over a valid/ready handshake and buffers them in a small FIFO.
- Presents each buffered code as an 8-bit one-hot word on a valid/ready output handshake.
- Sits between a binary code producer and one-hot consumers (select lines, LED/segment drivers); also provides a running count of delivered words.

---
 rtl/binary_octal_stream_dec.sv | 100 ++++++++++
 1 files changed

// File: rtl/binary_octal_stream_dec.sv
// binary_octal_stream_dec: streaming 3-to-8 decoder behind a small FIFO.
// Buffers 3-bit binary codes from a valid/ready producer. It presents the head
// code as an 8-bit one-hot word on a valid/ready consumer interface, and it
// counts the words that the consumer has accepted.
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                synchronous clear of FIFO contents (count is kept)
//   bin_valid/ready/bin  input handshake and 3-bit code
//   oct_valid/ready/oct  output handshake and one-hot word
//   level                FIFO occupancy, 0..DEPTH
//   count                delivered-word counter, wraps modulo 2^CNT_W
module binary_octal_stream_dec #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   bin_valid,
    output logic                   bin_ready,
    input  logic [2:0]             bin,
    output logic                   oct_valid,
    input  logic                   oct_ready,
    output logic [7:0]             oct,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CODE_W = 3;

    logic [CODE_W-1:0] mem_q [DEPTH];
    logic [CODE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    // Handshake flags come from registered occupancy only.
    assign bin_ready = (level_q != LVL_W'(DEPTH));
    assign oct_valid = (level_q != LVL_W'(0));
    assign push      = bin_valid && bin_ready;
    assign pop       = oct_valid && oct_ready;

    // The stored code is decoded on the read side.
    assign oct   = oct_valid ? 8'(8'h01 << mem_q[rd_ptr_q]) : 8'h00;
    assign level = level_q;
    assign count = count_q;

    // Next-state logic. A flush takes priority and discards any push or pop
    // in the same cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            level_d  = LVL_W'(0);
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = bin;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                count_d  = count_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   level_d = level_q + LVL_W'(1);
                2'b01:   level_d = level_q - LVL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= CODE_W'(0);
            end
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            level_q  <= LVL_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

endmodule
